wb_rom_loader: RTL
==================

Name: wb_rom_loader

Overview:
- Wishbone pipelined initiator (bus master) that copies a block of words from a combinational-read ROM port into the FPGA block RAM.
- It drives the same request/stall/ack interface the block RAM responds to, as the writer side of that protocol.
- Used to preload data memory from the program ROM before releasing the hart.
- Keeps up to MAX_OUTSTANDING write requests in flight and tracks acks, bus errors and ack timeout.

Parameters:
- XLEN, 32, data and address width.
- CNT_W, 10, width of word-count input (max 1023 words per transfer).
- MAX_OUTSTANDING, 4, maximum accepted-but-unacked requests (1..15).
- TIMEOUT, 64, cycles without ack while requests are outstanding before abort.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle start strobe; ignored unless idle.
- i_src_base  in  XLEN  ROM byte address of first word.
- i_dst_base  in  XLEN  RAM byte address of first word.
- i_count  in  CNT_W  number of words to copy.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done; 1 = misaligned, bus error or timeout.
- o_rom_addr  out  XLEN  ROM byte address; the ROM returns data combinationally.
- i_rom_data  in  XLEN  ROM read data.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone cycle, strobe, write-enable.
- o_wb_addr  out  XLEN  RAM byte address.
- o_wb_data  out  XLEN  write data, driven directly from i_rom_data.
- o_wb_sel  out  4  byte lanes; always 4'hF while o_wb_stb is high.
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  responder stall, ack, error.

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0; internal counters cleared. Any in-flight transfer is abandoned with no o_done.
- State IDLE:
  - i_start with i_count==0 -> DONE, err=0, no bus activity.
  - i_start with i_src_base[1:0]!=0 or i_dst_base[1:0]!=0 -> DONE, err=1, no bus activity.
  - Otherwise latch the src/dst pointers and count, then go to ISSUE.
- State ISSUE:
  - o_busy=1 and o_wb_cyc=1. o_wb_we=1.
  - o_wb_stb=1 while issued<count and outstanding<MAX_OUTSTANDING.
  - o_rom_addr = src pointer; o_wb_addr = dst pointer.
  - A request is accepted when stb && !i_wb_stall. On acceptance, both pointers advance by 4 and issued and outstanding each increment.
  - While stalled, address and data hold stable (the ROM address is unchanged, so the data is too).
  - When issued==count -> DRAIN, with stb low.
- State DRAIN: cyc stays high and stb stays low until acked==count, then go to DONE with err=0.
- Ack handling:
  - Each i_wb_ack decrements outstanding and increments acked, in ISSUE or DRAIN.
  - Acceptance and ack in the same cycle leave outstanding unchanged.
  - An ack arriving with outstanding==0 is ignored.
- Latency: i_start at edge N gives cyc and stb high after edge N+1. The first write is accepted at edge N+2 if stall is low.
- Throughput: one word per cycle when there is no stall and acks return within MAX_OUTSTANDING cycles.
- Error (ISSUE or DRAIN): i_wb_err drops cyc and stb on the next edge (abort). Go to DONE with err=1; remaining words are not written.
- Timeout (ISSUE or DRAIN):
  - Timer resets on every ack and whenever outstanding==0.
  - It counts while outstanding>0 and no ack arrives.
  - Reaching TIMEOUT aborts the transfer exactly like i_wb_err.
- State DONE: lasts one cycle with o_done=1 and o_busy=0, then IDLE. i_start in that cycle is ignored.
- i_start while busy is ignored; it does not restart or re-latch inputs.
- Pointers wrap modulo 2^XLEN with no error.

Test Plan:
- Copy 8 words, src=0x0, dst=0x100, stall=0, ack one cycle after accept:
  - 8 writes to 0x100..0x11C carrying ROM words 0..7.
  - o_done high 10 cycles after the first stb; err=0.
- Same copy with stall asserted on every other cycle and ack delayed 3 cycles:
  - Outstanding never exceeds 4.
  - Address and data are stable across stalls.
  - Exactly 8 accepts and 8 acks.
- i_count=0, then dst=0x102:
  - Each gives o_done two cycles after start, with err=0 and err=1 respectively.
  - cyc never rises in either case.
- i_wb_err on the 3rd ack of a 6-word copy:
  - cyc low the next cycle; o_done with err=1.
  - Only words 0..2 are acked, and no further stb.
- Acks withheld after 2 accepts with TIMEOUT=64:
  - Abort with err=1 exactly 64 cycles after the last accept.
- Reset asserted mid-ISSUE, plus i_start pulsed while busy:
  - Reset drives all outputs to 0 immediately, with no o_done.
  - The start pulse while busy does not alter the count or addresses.

Source files
------------

// File: rtl/wb_rom_loader.sv
// Wishbone pipelined write initiator copying words from a combinational ROM port into block RAM.
// First stb two edges after i_start; holds address/data under i_wb_stall, max MAX_OUTSTANDING unacked.
module wb_rom_loader #(
   parameter int XLEN            = 32,
   parameter int CNT_W           = 10,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT         = 64
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_start,
   input  logic [XLEN-1:0] i_src_base,
   input  logic [XLEN-1:0] i_dst_base,
   input  logic [CNT_W-1:0] i_count,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_err,
   output logic [XLEN-1:0] o_rom_addr,
   input  logic [XLEN-1:0] i_rom_data,
   output logic            o_wb_cyc,
   output logic            o_wb_stb,
   output logic            o_wb_we,
   output logic [XLEN-1:0] o_wb_addr,
   output logic [XLEN-1:0] o_wb_data,
   output logic [3:0]      o_wb_sel,
   input  logic            i_wb_stall,
   input  logic            i_wb_ack,
   input  logic            i_wb_err
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
   localparam logic [TW-1:0] TO_T  = TW'(TIMEOUT);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       r_state;
   logic [XLEN-1:0]  r_src;
   logic [XLEN-1:0]  r_dst;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_acked;
   logic [OW-1:0]    r_outs;
   logic [TW-1:0]    r_timer;
   logic             r_err;

   logic w_active;
   logic w_stb;
   logic w_acc;
   logic w_ack;
   logic w_abort;

   assign w_active = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign w_stb    = (r_state == S_ISSUE) && (r_issued < r_cnt) && (r_outs < MAX_O);
   assign w_acc    = w_stb && !i_wb_stall;
   // A stray ack with nothing outstanding must not underflow the counters.
   assign w_ack    = w_active && i_wb_ack && (r_outs != '0);
   assign w_abort  = w_active && (i_wb_err || (r_timer == TO_T));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= S_IDLE;
         r_src    <= '0;
         r_dst    <= '0;
         r_cnt    <= '0;
         r_issued <= '0;
         r_acked  <= '0;
         r_outs   <= '0;
         r_timer  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_active) begin
            if (w_acc) begin
               r_src    <= r_src + XLEN'(4);
               r_dst    <= r_dst + XLEN'(4);
               r_issued <= r_issued + 1'b1;
            end
            if (w_ack)
               r_acked <= r_acked + 1'b1;
            case ({w_acc, w_ack})
               2'b10:   r_outs <= r_outs + 1'b1;
               2'b01:   r_outs <= r_outs - 1'b1;
               default: r_outs <= r_outs;
            endcase
            if (w_ack || (r_outs == '0))
               r_timer <= '0;
            else if (r_timer != TO_T)
               r_timer <= r_timer + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_src    <= i_src_base;
                  r_dst    <= i_dst_base;
                  r_cnt    <= i_count;
                  r_issued <= '0;
                  r_acked  <= '0;
                  r_outs   <= '0;
                  r_timer  <= '0;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (r_cnt == '0) begin
                  r_err   <= 1'b0;
                  r_state <= S_DONE;
               end else if ((r_src[1:0] != 2'b00) || (r_dst[1:0] != 2'b00)) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_abort) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_issued == r_cnt) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_abort) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_acked == r_cnt) begin
                  r_err   <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy     = (r_state == S_LOAD) || w_active;
   assign o_done     = (r_state == S_DONE);
   assign o_err      = (r_state == S_DONE) && r_err;
   assign o_rom_addr = r_src;
   assign o_wb_cyc   = w_active;
   assign o_wb_stb   = w_stb;
   assign o_wb_we    = w_active;
   assign o_wb_addr  = r_dst;
   assign o_wb_data  = w_active ? i_rom_data : '0;
   assign o_wb_sel   = {4{w_stb}};

endmodule
